// File: rtl/ps2_kbd_pkg.sv
// Shared scan-set-2 constants and prefix FSM encoding for the keyboard text stage.
package ps2_kbd_pkg;
    localparam logic [7:0] SC_BREAK    = 8'hF0;
    localparam logic [7:0] SC_EXT      = 8'hE0;
    localparam logic [7:0] SC_LSHIFT   = 8'h12;
    localparam logic [7:0] SC_RSHIFT   = 8'h59;
    localparam logic [7:0] SC_CAPS     = 8'h58;
    localparam logic [7:0] SC_ENTER    = 8'h5A;
    localparam logic [7:0] SC_BKSP     = 8'h66;
    localparam logic [7:0] ASCII_SPACE = 8'h20;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;
endpackage

// File: rtl/ps2_kbd_text_scan2ascii.sv
// Combinational scan-set-2 make code to ASCII lookup; 00 for unmapped codes.
module kbd_scan2ascii (
    input  logic [7:0] code,
    input  logic       shift,
    input  logic       caps,
    output logic [7:0] ascii
);
    logic       letter;
    logic [7:0] base;
    logic [7:0] alt;

    always_comb begin
        {letter, base, alt} = {1'b0, 8'h00, 8'h00};
        case (code)
            8'h1C: {letter, base, alt} = {1'b1, 8'h61, 8'h41};
            8'h32: {letter, base, alt} = {1'b1, 8'h62, 8'h42};
            8'h21: {letter, base, alt} = {1'b1, 8'h63, 8'h43};
            8'h23: {letter, base, alt} = {1'b1, 8'h64, 8'h44};
            8'h24: {letter, base, alt} = {1'b1, 8'h65, 8'h45};
            8'h2B: {letter, base, alt} = {1'b1, 8'h66, 8'h46};
            8'h34: {letter, base, alt} = {1'b1, 8'h67, 8'h47};
            8'h33: {letter, base, alt} = {1'b1, 8'h68, 8'h48};
            8'h43: {letter, base, alt} = {1'b1, 8'h69, 8'h49};
            8'h3B: {letter, base, alt} = {1'b1, 8'h6A, 8'h4A};
            8'h42: {letter, base, alt} = {1'b1, 8'h6B, 8'h4B};
            8'h4B: {letter, base, alt} = {1'b1, 8'h6C, 8'h4C};
            8'h3A: {letter, base, alt} = {1'b1, 8'h6D, 8'h4D};
            8'h31: {letter, base, alt} = {1'b1, 8'h6E, 8'h4E};
            8'h44: {letter, base, alt} = {1'b1, 8'h6F, 8'h4F};
            8'h4D: {letter, base, alt} = {1'b1, 8'h70, 8'h50};
            8'h15: {letter, base, alt} = {1'b1, 8'h71, 8'h51};
            8'h2D: {letter, base, alt} = {1'b1, 8'h72, 8'h52};
            8'h1B: {letter, base, alt} = {1'b1, 8'h73, 8'h53};
            8'h2C: {letter, base, alt} = {1'b1, 8'h74, 8'h54};
            8'h3C: {letter, base, alt} = {1'b1, 8'h75, 8'h55};
            8'h2A: {letter, base, alt} = {1'b1, 8'h76, 8'h56};
            8'h1D: {letter, base, alt} = {1'b1, 8'h77, 8'h57};
            8'h22: {letter, base, alt} = {1'b1, 8'h78, 8'h58};
            8'h35: {letter, base, alt} = {1'b1, 8'h79, 8'h59};
            8'h1A: {letter, base, alt} = {1'b1, 8'h7A, 8'h5A};
            8'h16: {letter, base, alt} = {1'b0, 8'h31, 8'h21};
            8'h1E: {letter, base, alt} = {1'b0, 8'h32, 8'h40};
            8'h26: {letter, base, alt} = {1'b0, 8'h33, 8'h23};
            8'h25: {letter, base, alt} = {1'b0, 8'h34, 8'h24};
            8'h2E: {letter, base, alt} = {1'b0, 8'h35, 8'h25};
            8'h36: {letter, base, alt} = {1'b0, 8'h36, 8'h5E};
            8'h3D: {letter, base, alt} = {1'b0, 8'h37, 8'h26};
            8'h3E: {letter, base, alt} = {1'b0, 8'h38, 8'h2A};
            8'h46: {letter, base, alt} = {1'b0, 8'h39, 8'h28};
            8'h45: {letter, base, alt} = {1'b0, 8'h30, 8'h29};
            8'h29: {letter, base, alt} = {1'b0, 8'h20, 8'h20};
            8'h0E: {letter, base, alt} = {1'b0, 8'h60, 8'h7E};
            8'h4E: {letter, base, alt} = {1'b0, 8'h2D, 8'h5F};
            8'h55: {letter, base, alt} = {1'b0, 8'h3D, 8'h2B};
            8'h54: {letter, base, alt} = {1'b0, 8'h5B, 8'h7B};
            8'h5B: {letter, base, alt} = {1'b0, 8'h5D, 8'h7D};
            8'h5D: {letter, base, alt} = {1'b0, 8'h5C, 8'h7C};
            8'h4C: {letter, base, alt} = {1'b0, 8'h3B, 8'h3A};
            8'h52: {letter, base, alt} = {1'b0, 8'h27, 8'h22};
            8'h41: {letter, base, alt} = {1'b0, 8'h2C, 8'h3C};
            8'h49: {letter, base, alt} = {1'b0, 8'h2E, 8'h3E};
            8'h4A: {letter, base, alt} = {1'b0, 8'h2F, 8'h3F};
            default: ;
        endcase
        // Caps only flips letters; punctuation follows Shift alone.
        ascii = (letter ? (shift ^ caps) : shift) ? alt : base;
    end
endmodule

// File: rtl/ps2_kbd_text.sv
// PS/2 scan bytes in, text-memory writes out: prefix FSM, modifier state and cursor tracking.
module ps2_kbd_text
    import ps2_kbd_pkg::*;
#(
    parameter int COLS   = 80,
    parameter int ROWS   = 60,
    parameter int ADDR_W = 13
) (
    input  logic              CLK_50M,
    input  logic              RESET_N,
    input  logic              code_tick,
    input  logic [7:0]        code,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_data,
    output logic [ADDR_W-1:0] cursor_addr,
    output logic              shift_o,
    output logic              caps_o
);
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);

    logic [1:0]        st_q, st_d;
    logic              lsh_q, lsh_d, rsh_q, rsh_d, caps_q, caps_d;
    logic [CW-1:0]     col_q, col_d;
    logic [RW-1:0]     row_q, row_d;
    logic [ADDR_W-1:0] cur_q, cur_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] waddr_q, waddr_d;
    logic [7:0]        wdata_q, wdata_d;
    logic [7:0]        ascii;

    kbd_scan2ascii u_lut (
        .code  (code),
        .shift (lsh_q | rsh_q),
        .caps  (caps_q),
        .ascii (ascii)
    );

    always_comb begin
        st_d    = st_q;
        lsh_d   = lsh_q;
        rsh_d   = rsh_q;
        caps_d  = caps_q;
        col_d   = col_q;
        row_d   = row_q;
        cur_d   = cur_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (code_tick) begin
            case (st_q)
                ST_IDLE: begin
                    if (code == SC_BREAK) st_d = ST_BRK;
                    else if (code == SC_EXT) st_d = ST_EXT;
                    else begin
                        case (code)
                            SC_LSHIFT: lsh_d  = 1'b1;
                            SC_RSHIFT: rsh_d  = 1'b1;
                            SC_CAPS:   caps_d = ~caps_q;
                            SC_ENTER: begin
                                col_d = '0;
                                if (row_q == RW'(ROWS - 1)) begin
                                    row_d = '0;
                                    cur_d = '0;
                                end else begin
                                    row_d = row_q + RW'(1);
                                    // Linear address tracks col/row without a multiplier.
                                    cur_d = cur_q + ADDR_W'(COLS) - ADDR_W'(col_q);
                                end
                            end
                            SC_BKSP: begin
                                we_d    = 1'b1;
                                wdata_d = ASCII_SPACE;
                                waddr_d = cur_q;
                                if (cur_q != '0) begin
                                    cur_d   = cur_q - ADDR_W'(1);
                                    waddr_d = cur_q - ADDR_W'(1);
                                    if (col_q == '0) begin
                                        col_d = CW'(COLS - 1);
                                        row_d = row_q - RW'(1);
                                    end else begin
                                        col_d = col_q - CW'(1);
                                    end
                                end
                            end
                            default: begin
                                if (ascii != 8'h00) begin
                                    we_d    = 1'b1;
                                    waddr_d = cur_q;
                                    wdata_d = ascii;
                                    if (col_q == CW'(COLS - 1)) begin
                                        col_d = '0;
                                        if (row_q == RW'(ROWS - 1)) begin
                                            row_d = '0;
                                            cur_d = '0;
                                        end else begin
                                            row_d = row_q + RW'(1);
                                            cur_d = cur_q + ADDR_W'(1);
                                        end
                                    end else begin
                                        col_d = col_q + CW'(1);
                                        cur_d = cur_q + ADDR_W'(1);
                                    end
                                end
                            end
                        endcase
                    end
                end
                ST_BRK: begin
                    if (code == SC_LSHIFT) lsh_d = 1'b0;
                    if (code == SC_RSHIFT) rsh_d = 1'b0;
                    st_d = ST_IDLE;
                end
                ST_EXT:  st_d = (code == SC_BREAK) ? ST_EXT_BRK : ST_IDLE;
                default: st_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge CLK_50M or negedge RESET_N) begin
        if (!RESET_N) begin
            st_q    <= ST_IDLE;
            lsh_q   <= 1'b0;
            rsh_q   <= 1'b0;
            caps_q  <= 1'b0;
            col_q   <= '0;
            row_q   <= '0;
            cur_q   <= '0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            st_q    <= st_d;
            lsh_q   <= lsh_d;
            rsh_q   <= rsh_d;
            caps_q  <= caps_d;
            col_q   <= col_d;
            row_q   <= row_d;
            cur_q   <= cur_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    assign mem_we      = we_q;
    assign mem_addr    = waddr_q;
    assign mem_data    = wdata_q;
    assign cursor_addr = cur_q;
    assign shift_o     = lsh_q | rsh_q;
    assign caps_o      = caps_q;
endmodule
